// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// Resolution end of the branch predictor interface. Every fetched instruction
// leaves its prediction (pc, 2-bit counter state, predicted next pc) in an
// in-order circular queue. When execute resolves the oldest instruction, the
// predicted next pc is compared with the real one. The result drives the local
// branch table update port, and on a mispredict it flushes and redirects fetch.
//
// Optional feature: define BRQ_STATS_EN to add saturating branch/mispredict
// counters (stat_branches, stat_mispredicts). With the macro undefined the
// ports and the counters do not exist.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fetch_valid/ready     push handshake (ready = queue not full)
//   fetch_pc              pc of the fetched instruction
//   fetch_prediction      2-bit table state read at fetch (snt/wnt/wt/st)
//   fetch_pc_prediction   next pc that fetch actually used
//   resolve_valid/ready   pop handshake for the oldest entry (ready = not empty)
//   resolve_is_br         resolved instruction is a conditional branch/jump
//   resolve_taken         actual direction
//   resolve_target        computed branch target
//   update                one-cycle table write strobe
//   correct               direction prediction was right
//   pc_update             pc of the resolved branch
//   previous_prediction   table state captured at fetch
//   calculated_target     resolve_target of the resolved branch
//   flush                 one-cycle mispredict pulse
//   redirect_pc           correct next pc, valid while flush=1
//   stat_branches         (BRQ_STATS_EN) count of update pulses
//   stat_mispredicts      (BRQ_STATS_EN) count of flush pulses
module branch_resolve_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_pc,
    input  logic [1:0]  fetch_prediction,
    input  logic [31:0] fetch_pc_prediction,
    input  logic        resolve_valid,
    output logic        resolve_ready,
    input  logic        resolve_is_br,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic        update,
    output logic        correct,
    output logic [31:0] pc_update,
    output logic [1:0]  previous_prediction,
    output logic [31:0] calculated_target,
    output logic        flush,
    output logic [31:0] redirect_pc
`ifdef BRQ_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] SNT = 2'b00;

    logic [31:0]   pc_mem   [DEPTH];
    logic [1:0]    pred_mem [DEPTH];
    logic [31:0]   pcp_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0]   head_pc;
    logic [1:0]    head_pred;
    logic [31:0]   head_pcp;
    logic [31:0]   actual_next;
    logic          pred_taken;
    logic          dir_ok;
    logic          mispredict;
    logic          do_push;
    logic          do_pop;
    logic          flush_now;

    assign fetch_ready   = (count != FULL_COUNT);
    assign resolve_ready = (count != '0);

    assign head_pc   = pc_mem[head];
    assign head_pred = pred_mem[head];
    assign head_pcp  = pcp_mem[head];

    // The upper bit of the 2-bit counter is the predicted direction (wt/st).
    assign actual_next = resolve_taken ? resolve_target : head_pc + 32'd4;
    assign pred_taken  = head_pred[1];
    assign dir_ok      = (pred_taken == resolve_taken);
    assign mispredict  = (actual_next != head_pcp);

    // A pop is ignored during the flush pulse; the ready flags come from the
    // registered count, so a full queue refuses a push even if it pops.
    assign do_push   = fetch_valid && fetch_ready;
    assign do_pop    = resolve_valid && resolve_ready && !flush;
    assign flush_now = do_pop && mispredict;

    // Entry storage needs no reset: only slots between head and tail are read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail]   <= fetch_pc;
            pred_mem[tail] <= fetch_prediction;
            pcp_mem[tail]  <= fetch_pc_prediction;
        end
    end

    // Pointers and occupancy. A mispredict empties the queue because every
    // younger entry was fetched down the wrong path, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_now) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Table update port and fetch redirect. Data outputs only move when they
    // carry new information, so they hold their previous value otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            update              <= 1'b0;
            correct             <= 1'b0;
            pc_update           <= '0;
            previous_prediction <= SNT;
            calculated_target   <= '0;
            flush               <= 1'b0;
            redirect_pc         <= '0;
        end else begin
            update <= do_pop && resolve_is_br;
            flush  <= flush_now;
            if (do_pop && resolve_is_br) begin
                correct             <= dir_ok;
                pc_update           <= head_pc;
                previous_prediction <= head_pred;
                calculated_target   <= resolve_target;
            end
            if (flush_now) redirect_pc <= actual_next;
        end
    end

`ifdef BRQ_STATS_EN
    // Counters advance on the same edge that raises update/flush, so they are
    // current whenever the pulse is visible. They saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_pop && resolve_is_br && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (flush_now && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue
// Self-checking bench for branch_resolve_queue. A behavioural model that uses a
// queue of predictions predicts every output after each clock. Directed
// scenarios run first, then a randomized stretch follows. Inputs change on the
// falling edge, and outputs are compared on the next falling edge.
// The BRQ_STATS_EN counters are checked when that macro is defined.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam logic [1:0] SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  pred;
        logic [31:0] pcp;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_prediction;
    logic [31:0] fetch_pc_prediction;
    logic        resolve_valid;
    logic        resolve_ready;
    logic        resolve_is_br;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        update;
    logic        correct;
    logic [31:0] pc_update;
    logic [1:0]  previous_prediction;
    logic [31:0] calculated_target;
    logic        flush;
    logic [31:0] redirect_pc;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total_checks = 0;
    int bad_checks   = 0;

    // Reference model state.
    entry_t      q[$];
    logic        exp_update, exp_correct, exp_flush;
    logic [31:0] exp_pcu, exp_tgt, exp_redir;
    logic [1:0]  exp_prev;
    logic [31:0] exp_sb, exp_sm;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_pc            (fetch_pc),
        .fetch_prediction    (fetch_prediction),
        .fetch_pc_prediction (fetch_pc_prediction),
        .resolve_valid       (resolve_valid),
        .resolve_ready       (resolve_ready),
        .resolve_is_br       (resolve_is_br),
        .resolve_taken       (resolve_taken),
        .resolve_target      (resolve_target),
        .update              (update),
        .correct             (correct),
        .pc_update           (pc_update),
        .previous_prediction (previous_prediction),
        .calculated_target   (calculated_target),
        .flush               (flush),
        .redirect_pc         (redirect_pc)
`ifdef BRQ_STATS_EN
        ,
        .stat_branches       (stat_branches),
        .stat_mispredicts    (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("fetch_ready", 32'(fetch_ready), 32'(q.size() < DEPTH));
        checkOutput("resolve_ready", 32'(resolve_ready), 32'(q.size() != 0));
        checkOutput("update", 32'(update), 32'(exp_update));
        checkOutput("correct", 32'(correct), 32'(exp_correct));
        checkOutput("pc_update", pc_update, exp_pcu);
        checkOutput("previous_prediction", 32'(previous_prediction), 32'(exp_prev));
        checkOutput("calculated_target", calculated_target, exp_tgt);
        checkOutput("flush", 32'(flush), 32'(exp_flush));
        checkOutput("redirect_pc", redirect_pc, exp_redir);
`ifdef BRQ_STATS_EN
        checkOutput("stat_branches", stat_branches, exp_sb);
        checkOutput("stat_mispredicts", stat_mispredicts, exp_sm);
`endif
    endtask

    // One clock: check the outputs of the last edge, drive new inputs, and
    // predict what the coming edge will produce.
    task automatic applyStimulus(input logic fv, input logic [31:0] fpc, input logic [1:0] fpred,
                                 input logic [31:0] fpcp, input logic rv, input logic br,
                                 input logic tk, input logic [31:0] tgt);
        entry_t      e;
        logic [31:0] actual;
        logic        push_ok, pop_ok;
        @(negedge clk);
        checkAll();
        fetch_valid         = fv;
        fetch_pc            = fpc;
        fetch_prediction    = fpred;
        fetch_pc_prediction = fpcp;
        resolve_valid       = rv;
        resolve_is_br       = br;
        resolve_taken       = tk;
        resolve_target      = tgt;

        push_ok    = fv && (q.size() < DEPTH);
        pop_ok     = rv && (q.size() > 0) && !exp_flush;
        exp_update = 1'b0;
        exp_flush  = 1'b0;
        if (pop_ok) begin
            e      = q[0];
            actual = tk ? tgt : e.pc + 32'd4;
            if (br) begin
                exp_update  = 1'b1;
                exp_correct = ((e.pred == WT) || (e.pred == ST)) == tk;
                exp_pcu     = e.pc;
                exp_prev    = e.pred;
                exp_tgt     = tgt;
                if (exp_sb != 32'hFFFF_FFFF) exp_sb++;
            end
            if (actual != e.pcp) begin
                exp_flush = 1'b1;
                exp_redir = actual;
                if (exp_sm != 32'hFFFF_FFFF) exp_sm++;
                q.delete();
                push_ok = 1'b0;
            end else begin
                void'(q.pop_front());
            end
        end
        if (push_ok) begin
            e.pc   = fpc;
            e.pred = fpred;
            e.pcp  = fpcp;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 32'h0, SNT, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic pushOnly(input logic [31:0] pc, input logic [1:0] pred, input logic [31:0] pcp);
        applyStimulus(1'b1, pc, pred, pcp, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolveOnly(input logic br, input logic tk, input logic [31:0] tgt);
        applyStimulus(1'b0, 32'h0, SNT, 32'h0, 1'b1, br, tk, tgt);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        fetch_valid = 1'b0;
        resolve_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_update = 1'b0; exp_correct = 1'b0; exp_flush = 1'b0;
        exp_pcu = '0; exp_tgt = '0; exp_redir = '0; exp_prev = SNT;
        exp_sb = '0; exp_sm = '0;
    endtask

    initial begin
        logic [31:0] pc, pcp, tgt;
        logic        br, tk;
        entry_t      h;

        rst = 1'b1;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_prediction = SNT; fetch_pc_prediction = '0;
        resolve_valid = 1'b0; resolve_is_br = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        doReset();
        idle(2);

        // Correctly predicted taken branch.
        pushOnly(32'h100, WT, 32'h140);
        resolveOnly(1'b1, 1'b1, 32'h140);
        idle(2);

        // Mispredicted branch with younger wrong-path entries and a discarded same-cycle push.
        pushOnly(32'h200, WNT, 32'h204);
        pushOnly(32'h204, SNT, 32'h208);
        pushOnly(32'h208, SNT, 32'h20C);
        applyStimulus(1'b1, 32'h20C, SNT, 32'h210, 1'b1, 1'b1, 1'b1, 32'h300);
        resolveOnly(1'b1, 1'b1, 32'h300);
        idle(2);

        // Fill to full, refuse the 9th push, pop+push at full, then drain across the wrap.
        for (int i = 0; i < DEPTH + 1; i++)
            pushOnly(32'h1000 + 32'(i * 4), SNT, 32'h1004 + 32'(i * 4));
        applyStimulus(1'b1, 32'h2000, SNT, 32'h2004, 1'b1, 1'b1, 1'b0, 32'h0);
        pushOnly(32'h3000, ST, 32'h3100);
        for (int i = 0; i < DEPTH; i++)
            resolveOnly(1'b1, 1'b0, 32'h0);
        resolveOnly(1'b1, 1'b1, 32'h3100);
        idle(2);

        // Non-branch with an aliased BTB prediction.
        pushOnly(32'h400, SNT, 32'h500);
        resolveOnly(1'b0, 1'b0, 32'h0);
        idle(2);

        // Resolve with an empty queue is ignored.
        resolveOnly(1'b1, 1'b1, 32'h999);
        idle(1);

        // Reset in the middle of operation.
        pushOnly(32'h600, WT, 32'h700);
        pushOnly(32'h604, WT, 32'h700);
        doReset();
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            pc  = 32'h1000 + ($urandom_range(0, 63) << 2);
            pcp = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : 32'h2000 + ($urandom_range(0, 15) << 2);
            if (q.size() > 0 && $urandom_range(0, 9) < 7) begin
                h  = q[0];
                br = 1'b1;
                tk = (h.pcp != h.pc + 32'd4);
                tgt = tk ? h.pcp : 32'h2000 + ($urandom_range(0, 15) << 2);
            end else begin
                br  = ($urandom_range(0, 4) != 0);
                tk  = br ? 1'($urandom_range(0, 1)) : 1'b0;
                tgt = 32'h2000 + ($urandom_range(0, 15) << 2);
            end
            applyStimulus(1'($urandom_range(0, 9) < 6), pc, 2'($urandom_range(0, 3)), pcp,
                          1'($urandom_range(0, 1)), br, tk, tgt);
        end
        idle(2);

`ifdef BRQ_STATS_EN
        // Three correct branches and one mispredict after a clean reset.
        doReset();
        for (int i = 0; i < 3; i++) begin
            pushOnly(32'h800 + 32'(i * 16), ST, 32'h900);
            resolveOnly(1'b1, 1'b1, 32'h900);
        end
        pushOnly(32'h880, SNT, 32'h884);
        resolveOnly(1'b1, 1'b1, 32'hA00);
        idle(2);
        checkOutput("stat_branches_total", stat_branches, 32'd4);
        checkOutput("stat_mispredicts_total", stat_mispredicts, 32'd1);
        doReset();
        idle(1);
        checkOutput("stat_branches_cleared", stat_branches, 32'd0);
        checkOutput("stat_mispredicts_cleared", stat_mispredicts, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
